// File: rtl/island_peak_extractor.sv
// ============================================================================
// Module      : island_peak_extractor
// Description : Per-island peak, peak position, integral and length of a
//               multi-lane signed sample stream gated by trig.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module island_peak_extractor #(
    parameter int BITS     = 31,
    parameter int LANES    = 4,
    parameter int LEN_BITS = 16,
    parameter int SUM_BITS = BITS + LEN_BITS + $clog2(LANES)
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   trig,
    input  logic [LANES*BITS-1:0]                  in_data,
    input  logic                                   out_ready,
    output logic                                   out_valid,
    output logic signed [BITS-1:0]                 peak,
    output logic [LEN_BITS+$clog2(LANES)-1:0]      peak_pos,
    output logic signed [SUM_BITS-1:0]             integral,
    output logic [LEN_BITS-1:0]                    length,
    output logic                                   len_sat,
    output logic [15:0]                            drop_count
);

    localparam int C_LOG2L = $clog2(LANES);
    localparam int C_POS_W = LEN_BITS + C_LOG2L;
    localparam int C_NODES = 2 * LANES;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // Heap-ordered tree: node 1 is the root, leaves live at LANES..2*LANES-1.
    logic signed [BITS-1:0]     r_mx [1:C_NODES-1];
    logic [C_LOG2L-1:0]         r_ix [1:C_NODES-1];
    logic signed [SUM_BITS-1:0] r_sm [1:C_NODES-1];

    logic [C_LOG2L:0] r_trig_p;
    logic [C_LOG2L:0] r_end_p;
    logic             r_last_trig;

    state_t                     r_state, w_state_nx;
    logic signed [BITS-1:0]     r_peak,  w_peak_nx;
    logic [C_POS_W-1:0]         r_pos,   w_pos_nx;
    logic signed [SUM_BITS-1:0] r_sum,   w_sum_nx;
    logic [LEN_BITS-1:0]        r_len,   w_len_nx;
    logic                       r_sat,   w_sat_nx;

    logic w_t_trig;
    logic w_t_end;

    assign w_t_trig = r_trig_p[C_LOG2L];
    assign w_t_end  = r_end_p[C_LOG2L];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 1; i < C_NODES; i++) begin
                r_mx[i] <= '0;
                r_ix[i] <= '0;
                r_sm[i] <= '0;
            end
            r_trig_p    <= '0;
            r_end_p     <= '0;
            r_last_trig <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                r_mx[LANES+i] <= in_data[i*BITS +: BITS];
                r_ix[LANES+i] <= C_LOG2L'(i);
                r_sm[LANES+i] <= {{(SUM_BITS-BITS){in_data[i*BITS+BITS-1]}},
                                  in_data[i*BITS +: BITS]};
            end
            // Right child only wins when strictly greater, so lower lanes win ties.
            for (int i = 1; i < LANES; i++) begin
                if (r_mx[2*i+1] > r_mx[2*i]) begin
                    r_mx[i] <= r_mx[2*i+1];
                    r_ix[i] <= r_ix[2*i+1];
                end else begin
                    r_mx[i] <= r_mx[2*i];
                    r_ix[i] <= r_ix[2*i];
                end
                r_sm[i] <= r_sm[2*i] + r_sm[2*i+1];
            end
            r_trig_p    <= {r_trig_p[C_LOG2L-1:0], trig};
            r_end_p     <= {r_end_p[C_LOG2L-1:0], r_last_trig & ~trig};
            r_last_trig <= trig;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_peak_nx  = r_peak;
        w_pos_nx   = r_pos;
        w_sum_nx   = r_sum;
        w_len_nx   = r_len;
        w_sat_nx   = r_sat;
        case (r_state)
            S_IDLE: begin
                if (w_t_trig) begin
                    w_state_nx = S_ACTIVE;
                    w_peak_nx  = r_mx[1];
                    w_pos_nx   = {{LEN_BITS{1'b0}}, r_ix[1]};
                    w_sum_nx   = r_sm[1];
                    w_len_nx   = LEN_BITS'(1);
                    w_sat_nx   = 1'b0;
                end
            end
            S_ACTIVE: begin
                if (w_t_trig) begin
                    w_sum_nx = r_sum + r_sm[1];
                    if (r_len == '1) begin
                        w_sat_nx = 1'b1;
                    end else begin
                        w_len_nx = r_len + LEN_BITS'(1);
                    end
                    // Position freezes once the cycle offset no longer fits.
                    if (r_mx[1] > r_peak) begin
                        w_peak_nx = r_mx[1];
                        if (r_len != '1) begin
                            w_pos_nx = {r_len, r_ix[1]};
                        end
                    end
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_peak  <= '0;
            r_pos   <= '0;
            r_sum   <= '0;
            r_len   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_peak  <= w_peak_nx;
            r_pos   <= w_pos_nx;
            r_sum   <= w_sum_nx;
            r_len   <= w_len_nx;
            r_sat   <= w_sat_nx;
        end
    end

    // The end marker reaches the tree root one cycle after the island's last
    // samples were folded in, so the accumulator holds the finished result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            peak       <= '0;
            peak_pos   <= '0;
            integral   <= '0;
            length     <= '0;
            len_sat    <= 1'b0;
            drop_count <= '0;
        end else if (w_t_end) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                peak      <= r_peak;
                peak_pos  <= r_pos;
                integral  <= r_sum;
                length    <= r_len;
                len_sat   <= r_sat;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_island_peak_extractor.sv
// ============================================================================
// Module      : tb_island_peak_extractor
// Description : Directed self-checking bench for island_peak_extractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_island_peak_extractor;

    localparam int BITS     = 16;
    localparam int LANES    = 4;
    localparam int LEN_BITS = 8;
    localparam int SUM_BITS = 26;

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic                       trig = 1'b0;
    logic [LANES*BITS-1:0]      in_data = '0;
    logic                       out_ready = 1'b1;
    logic                       out_valid;
    logic signed [BITS-1:0]     peak;
    logic [LEN_BITS+1:0]        peak_pos;
    logic signed [SUM_BITS-1:0] integral;
    logic [LEN_BITS-1:0]        length;
    logic                       len_sat;
    logic [15:0]                drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    island_peak_extractor #(
        .BITS(BITS), .LANES(LANES), .LEN_BITS(LEN_BITS), .SUM_BITS(SUM_BITS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .trig(trig), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .peak(peak),
        .peak_pos(peak_pos), .integral(integral), .length(length),
        .len_sat(len_sat), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ncyc;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [63:0] d2;
        int          e_peak;
        int          e_pos;
        int          e_sum;
        int          e_len;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!out_valid && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int e_peak, input int e_pos,
                                input int e_sum, input int e_len, input int e_sat);
        check({tag, ".valid"},    out_valid, 1);
        check({tag, ".peak"},     peak, e_peak);
        check({tag, ".peak_pos"}, peak_pos, e_pos);
        check({tag, ".integral"}, integral, e_sum);
        check({tag, ".length"},   length, e_len);
        check({tag, ".len_sat"},  len_sat, e_sat);
    endtask

    initial begin
        int n;
        vecs[0] = '{1, pk(3, 9, -2, 9), 64'd0, 64'd0, 9, 1, 19, 1};
        vecs[1] = '{3, pk(1, 2, 5, 0), pk(0, 0, 12, 3), pk(0, 0, 12, 0), 12, 6, 35, 3};
        vecs[2] = '{1, pk(-5, -3, -3, -7), 64'd0, 64'd0, -3, 1, -18, 1};
        vecs[3] = '{2, pk(0, 0, 0, 0), pk(1, 0, 0, 0), 64'd0, 1, 4, 1, 2};
        vecs[4] = '{1, pk(-32768, 32767, 32767, -32768), 64'd0, 64'd0, 32767, 1, -2, 1};
        vecs[5] = '{2, pk(-1, -1, -1, -1), pk(-1, -1, -1, 0), 64'd0, 0, 7, -7, 2};

        tick();
        tick();
        check("reset.out_valid",  out_valid, 0);
        check("reset.peak",       peak, 0);
        check("reset.integral",   integral, 0);
        check("reset.drop_count", drop_count, 0);
        reset_n = 1'b1;
        tick();

        // Table vectors: exact latency of 4 cycles after the end cycle.
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < vecs[i].ncyc; c++) begin
                trig    = 1'b1;
                in_data = (c == 0) ? vecs[i].d0 : (c == 1) ? vecs[i].d1 : vecs[i].d2;
                tick();
            end
            trig    = 1'b0;
            in_data = '0;
            wait_valid(20, n);
            check($sformatf("vec%0d.latency", i), n, 4);
            check_result($sformatf("vec%0d", i), vecs[i].e_peak, vecs[i].e_pos,
                         vecs[i].e_sum, vecs[i].e_len, 0);
            tick();
            check($sformatf("vec%0d.clear", i), out_valid, 0);
            tick();
        end
        check("table.drop_count", drop_count, 0);

        // Long island saturates the length counter.
        for (int c = 0; c < 300; c++) begin
            trig    = 1'b1;
            in_data = pk(1, 1, 1, 1);
            tick();
        end
        trig    = 1'b0;
        in_data = '0;
        wait_valid(20, n);
        check_result("sat", 1, 0, 1200, 255, 1);
        tick();
        tick();

        // Back-pressure: second result dropped while first is held.
        out_ready = 1'b0;
        trig = 1'b1; in_data = pk(1, 2, 3, 4); tick();
        trig = 1'b0; in_data = '0;             tick();
        trig = 1'b1; in_data = pk(7, 0, 0, 0); tick();
        trig = 1'b0; in_data = '0;
        for (int c = 0; c < 8; c++) tick();
        check_result("bp", 4, 3, 10, 1, 0);
        check("bp.drop_count", drop_count, 1);
        out_ready = 1'b1;
        tick();
        check("bp.clear", out_valid, 0);
        tick();

        // Accept of the held result coincides with completion of the next one.
        out_ready = 1'b0;
        trig = 1'b1; in_data = pk(5, 0, 0, 0); tick();
        trig = 1'b0; in_data = '0;             tick();
        trig = 1'b1; in_data = pk(0, 0, 0, 6); tick();
        trig = 1'b0; in_data = '0;             tick();
        tick();
        check("b2b.first_valid", out_valid, 1);
        check("b2b.first_peak", peak, 5);
        tick();
        out_ready = 1'b1;
        check("b2b.first_hold", peak, 5);
        tick();
        check_result("b2b.second", 6, 3, 6, 1, 0);
        check("b2b.drop_count", drop_count, 1);
        tick();
        check("b2b.clear", out_valid, 0);
        tick();

        // Reset mid-island; a new island starts in the first cycle after reset.
        for (int c = 0; c < 3; c++) begin
            trig = 1'b1; in_data = pk(100, 100, 100, 100); tick();
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst.out_valid", out_valid, 0);
        check("rst.drop_count", drop_count, 0);
        trig = 1'b1; in_data = pk(2, 1, 0, 0); tick();
        trig = 1'b0; in_data = '0;
        wait_valid(20, n);
        check("rst.latency", n, 4);
        check_result("rst", 2, 0, 3, 1, 0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/island_peak_extractor.md
ISLAND_PEAK_EXTRACTOR -- requirements
Module: island_peak_extractor

Interface
REQ-001 Parameter BITS, default 31, signed sample width.
REQ-002 Parameter LANES, default 4, samples per clock; power of two, 2..16.
REQ-003 Parameter LEN_BITS, default 16, island-length counter width.
REQ-004 Parameter SUM_BITS, default BITS+LEN_BITS+log2(LANES), signed integral width.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 trig  in  1  current sample group is triggered.
REQ-008 in_data  in  LANES*BITS  signed samples; lane 0 in [BITS-1:0] is earliest in time.
REQ-009 out_ready  in  1  consumer accepts result.
REQ-010 out_valid  out  1  result registers hold an unaccepted result.
REQ-011 peak  out  BITS  signed maximum sample of island.
REQ-012 peak_pos  out  LEN_BITS+log2(LANES)  sample index of peak within island: cycle_offset*LANES+lane.
REQ-013 integral  out  SUM_BITS  signed sum of all island samples.
REQ-014 length  out  LEN_BITS  island length in clock cycles.
REQ-015 len_sat  out  1  island length exceeded counter range.
REQ-016 drop_count  out  16  islands discarded due to back-pressure.

Function
REQ-017 An island SHALL be a maximal run of consecutive cycles with trig=1; cycle_offset SHALL be 0 in its first cycle.
REQ-018 The island end cycle E SHALL be the first cycle with trig=0 after a trig=1 cycle; a single trig=0 cycle SHALL separate two distinct islands.
REQ-019 Per-cycle max SHALL use a registered binary compare tree of log2(LANES) stages; on ties, the lower lane SHALL win.
REQ-020 Across cycles, peak and peak_pos SHALL update only on strictly greater values, so the earliest occurrence wins.
REQ-021 The integral SHALL be computed in a pipeline aligned with the max tree, sign-extending samples and wrapping two's-complement at SUM_BITS.
REQ-022 The length counter SHALL saturate at 2^LEN_BITS-1 and set len_sat; past saturation, peak_pos SHALL freeze and integral SHALL keep accumulating.
REQ-023 The accumulator state SHALL be IDLE or ACTIVE; the first trig=1 entry SHALL load the first data, not combine with stale values.
REQ-024 Latency L SHALL be log2(LANES)+2: the completed result SHALL be captured and out_valid SHALL be 1 in cycle E+L.
REQ-025 out_valid SHALL stay 1 and result outputs SHALL stay stable until a cycle with out_valid=1 and out_ready=1; out_valid SHALL clear the following cycle unless a new result is captured in that same cycle.
REQ-026 If a result completes while out_valid=1 and out_ready=0 in that cycle, the new result SHALL be dropped and drop_count incremented, saturating at 65535.
REQ-027 If a result completes in the same cycle that the held result is accepted, the new result SHALL be captured and out_valid SHALL remain 1.
REQ-028 Back-to-back islands, including one-cycle islands, SHALL each yield an independent result, with no state leaking between islands.

Reset
REQ-029 While reset_n=0 in a cycle, on the next edge all outputs SHALL be 0, the pipeline SHALL be flushed, the state SHALL be IDLE and the internal last-trig register SHALL be 0.
REQ-030 An island in progress at reset SHALL be discarded and produce no out_valid.
REQ-031 trig=1 in the first cycle after reset SHALL start a new island.

Verification (BITS=16, LANES=4, LEN_BITS=8, L=4)
REQ-032 trig=1 for one cycle with data {lane0..3}={3,9,-2,9}, out_ready=1 -> out_valid in E+4; peak=9, peak_pos=1, integral=19, length=1.
REQ-033 Three-cycle island with per-cycle maxima 5,12,12 at lane 2 -> peak=12, peak_pos=6, length=3.
REQ-034 Island of 300 cycles, all samples 1 -> length=255, len_sat=1, integral=1200.
REQ-035 out_ready=0, two islands complete -> first result held, drop_count=1; set out_ready=1 -> one accept, out_valid clears next cycle.
REQ-036 reset_n=0 mid-island -> no out_valid; next island reports only its own data.
REQ-037 Islands separated by a single trig=0 cycle, with the first result accepted in the same cycle the second completes -> two valid results, the second captured without drop.
